// File: rtl/wgt_load_scheduler.sv
// Layer-level weight fetch sequencer.
// Splits a layer's filters into groups of SYSTOLIC_SIZE, kicks the weight
// address controller (wgt_start once per layer, wgt_load once per group),
// waits for each group fetch to drain, then steps the PE array through every
// output tile before moving to the next group.
// Optional build macro WGT_SCHED_TIMEOUT_EN adds a FETCH watchdog that raises
// the sticky fetch_err flag and aborts the layer; without it fetch_err is 0.
//
// state   | meaning
// IDLE    | waiting for layer_start
// CLEAR   | wgt_start pulse, weight base address cleared
// LOAD    | wgt_load pulse for the current group
// FETCH   | waiting for read_en to rise and fall again
// COMPUTE | issuing tile_start / counting tile_done for the resident group
// NEXT    | advance to next group or finish
// DONE    | layer_done pulse

module wgt_load_scheduler #(
    parameter int SYSTOLIC_SIZE  = 16,
    parameter int TILE_W         = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_start,
    input  logic [10:0]       num_filter,
    input  logic [TILE_W-1:0] num_out_tiles,
    input  logic              wgt_read_en,
    input  logic              tile_done,
    output logic              wgt_start,
    output logic              wgt_load,
    output logic              tile_start,
    output logic [7:0]        group_idx,
    output logic [TILE_W-1:0] tile_idx,
    output logic [4:0]        group_size,
    output logic              busy,
    output logic              layer_done,
    output logic              fetch_err
);

    // group_size is 5 bits and num_groups 8 bits; 2047 filters must fit both
    if (SYSTOLIC_SIZE < 9 || SYSTOLIC_SIZE > 31 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wgt_load_scheduler: unsupported SYSTOLIC_SIZE or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_FETCH,
        S_COMPUTE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [7:0]        num_groups, num_groups_n;
    logic [4:0]        rem, rem_n;
    logic [TILE_W-1:0] tiles, tiles_n;
    logic              seen_rd, seen_n;
    logic [7:0]        group_idx_n;
    logic [TILE_W-1:0] tile_idx_n;
    logic [4:0]        group_size_n;
    logic              wgt_start_n, wgt_load_n, tile_start_n, busy_n, layer_done_n;
    logic [7:0]        groups_calc;
    logic [4:0]        rem_calc;

`ifdef WGT_SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer, timer_n;
    logic             fetch_err_q, fetch_err_n;
`endif

    // Filters in group g: full width except a short final group
    function automatic logic [4:0] size_of(input logic [7:0] g,
                                           input logic [7:0] ngroups,
                                           input logic [4:0] remainder);
        if ((g == ngroups - 8'd1) && (remainder != 5'd0))
            return remainder;
        return 5'(SYSTOLIC_SIZE);
    endfunction

    // Group count and remainder from the live num_filter, latched at accept
    always_comb begin
        groups_calc = 8'((12'(num_filter) + 12'(SYSTOLIC_SIZE - 1)) / 12'(SYSTOLIC_SIZE));
        rem_calc    = 5'(num_filter % 11'(SYSTOLIC_SIZE));
    end

    // Next-state, counter updates and registered-output precompute
    always_comb begin
        state_n      = state;
        num_groups_n = num_groups;
        rem_n        = rem;
        tiles_n      = tiles;
        seen_n       = seen_rd;
        group_idx_n  = group_idx;
        tile_idx_n   = tile_idx;
        group_size_n = group_size;
`ifdef WGT_SCHED_TIMEOUT_EN
        timer_n      = timer;
        fetch_err_n  = fetch_err_q;
`endif
        case (state)
            S_IDLE: begin
                if (layer_start) begin
                    num_groups_n = groups_calc;
                    rem_n        = rem_calc;
                    tiles_n      = num_out_tiles;
                    group_idx_n  = '0;
                    tile_idx_n   = '0;
`ifdef WGT_SCHED_TIMEOUT_EN
                    fetch_err_n  = 1'b0;
`endif
                    if (num_filter == 11'd0 || num_out_tiles == '0)
                        state_n = S_DONE;
                    else
                        state_n = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_n      = S_LOAD;
                group_size_n = size_of(group_idx, num_groups, rem);
                seen_n       = 1'b0;
            end
            S_LOAD: begin
                state_n = S_FETCH;
            end
            S_FETCH: begin
                if (seen_rd && !wgt_read_en) begin
                    state_n    = S_COMPUTE;
                    tile_idx_n = '0;
                    seen_n     = 1'b0;
`ifdef WGT_SCHED_TIMEOUT_EN
                    timer_n    = '0;
`endif
                end
`ifdef WGT_SCHED_TIMEOUT_EN
                else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n     = S_DONE;
                    fetch_err_n = 1'b1;
                    timer_n     = '0;
                    seen_n      = 1'b0;
                end
`endif
                else begin
                    if (wgt_read_en)
                        seen_n = 1'b1;
`ifdef WGT_SCHED_TIMEOUT_EN
                    timer_n = timer + TMR_W'(1);
`endif
                end
            end
            S_COMPUTE: begin
                if (tile_done) begin
                    if (tile_idx == tiles - TILE_W'(1))
                        state_n = S_NEXT;
                    else
                        tile_idx_n = tile_idx + TILE_W'(1);
                end
            end
            S_NEXT: begin
                if (group_idx == num_groups - 8'd1) begin
                    state_n = S_DONE;
                end else begin
                    state_n      = S_LOAD;
                    group_idx_n  = group_idx + 8'd1;
                    group_size_n = size_of(group_idx + 8'd1, num_groups, rem);
                    seen_n       = 1'b0;
                end
            end
            S_DONE: begin
                state_n     = S_IDLE;
                group_idx_n = '0;
                tile_idx_n  = '0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered
        wgt_start_n  = (state_n == S_CLEAR);
        wgt_load_n   = (state_n == S_LOAD);
        layer_done_n = (state_n == S_DONE);
        busy_n       = (state_n != S_IDLE);
        tile_start_n = (state_n == S_COMPUTE) &&
                       ((state == S_FETCH) || (state == S_COMPUTE && tile_done));
    end

    // State, counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            num_groups <= '0;
            rem        <= '0;
            tiles      <= '0;
            seen_rd    <= 1'b0;
            group_idx  <= '0;
            tile_idx   <= '0;
            group_size <= '0;
            wgt_start  <= 1'b0;
            wgt_load   <= 1'b0;
            tile_start <= 1'b0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
        end else begin
            state      <= state_n;
            num_groups <= num_groups_n;
            rem        <= rem_n;
            tiles      <= tiles_n;
            seen_rd    <= seen_n;
            group_idx  <= group_idx_n;
            tile_idx   <= tile_idx_n;
            group_size <= group_size_n;
            wgt_start  <= wgt_start_n;
            wgt_load   <= wgt_load_n;
            tile_start <= tile_start_n;
            busy       <= busy_n;
            layer_done <= layer_done_n;
        end
    end

`ifdef WGT_SCHED_TIMEOUT_EN
    // FETCH watchdog counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer       <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            timer       <= timer_n;
            fetch_err_q <= fetch_err_n;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule
